// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// Hits are combinational; misses run a write-back/fetch handshake with the 256-bit line memory.
module dcache_controller #(
  parameter int unsigned INDEX_W = 5
) (
  input  logic         clock_i,
  input  logic         flush_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic         mem_ack_i,
  input  logic [255:0] mem_data_i
);

  localparam int unsigned NUM_LINES = 2 ** INDEX_W;
  localparam int unsigned TAG_W     = 27 - INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;

  state_t               state;
  logic [255:0]         data_mem [NUM_LINES];
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic [2:0]         word;
  logic               hit;
  logic               store_hit;
  logic [1:0]         unused_addr_bits;

  assign idx              = cpu_addr_i[5 +: INDEX_W];
  assign req_tag          = cpu_addr_i[31 -: TAG_W];
  assign word             = cpu_addr_i[4:2];
  assign unused_addr_bits = cpu_addr_i[1:0];

  assign hit       = cpu_req_i & valid[idx] & (tag_mem[idx] == req_tag);
  assign store_hit = (state == IDLE) & hit & cpu_write_i;

  // Control state and valid/dirty bits; flush leaves the tag and data arrays untouched.
  always_ff @(posedge clock_i or posedge flush_i) begin
    if (flush_i) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_i && !hit) begin
            if (valid[idx] && dirty[idx]) state <= WRITEBACK;
            else                          state <= ALLOCATE;
          end else if (store_hit) begin
            dirty[idx] <= 1'b1;
          end
        end
        WRITEBACK: if (mem_ack_i) state <= ALLOCATE;
        ALLOCATE:  if (mem_ack_i) state <= REFILL;
        REFILL: begin
          valid[idx] <= 1'b1;
          dirty[idx] <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line memory data arrives the cycle after ack, hence the fill happens in REFILL.
  always_ff @(posedge clock_i) begin
    if (!flush_i) begin
      if (state == REFILL) begin
        data_mem[idx] <= mem_data_i;
        tag_mem[idx]  <= req_tag;
      end else if (store_hit) begin
        data_mem[idx][{word, 5'b00000} +: 32] <= cpu_data_i;
      end
    end
  end

  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state)
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_mem[idx], idx, 5'b00000};
        mem_data_o   = data_mem[idx];
      end
      ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, idx, 5'b00000};
      end
      default: ;
    endcase
  end

  always_comb begin
    cpu_data_o  = hit ? data_mem[idx][{word, 5'b00000} +: 32] : '0;
    cpu_stall_o = (state != IDLE) | (cpu_req_i & ~hit);
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: a 10-wait-cycle line memory model, a vector
// table of CPU accesses with expected data/stall/traffic, plus reset and mid-miss flush sequences.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         flush = 1'b1;
  logic         cpu_req = 1'b0;
  logic         cpu_write = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_ack = 1'b0;
  logic [255:0] mem_rdata = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  dcache_controller #(.INDEX_W(5)) dut (
    .clock_i      (clk),
    .flush_i      (flush),
    .cpu_req_i    (cpu_req),
    .cpu_write_i  (cpu_write),
    .cpu_addr_i   (cpu_addr),
    .cpu_data_i   (cpu_wdata),
    .cpu_data_o   (cpu_data_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_ack_i    (mem_ack),
    .mem_data_i   (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Line memory: unwritten lines hold 0x1000_0000 | byte address of each word.
  logic [255:0] mem_store [int unsigned];
  logic [31:0]  wb_addr_log [$];
  logic [255:0] wb_data_log [$];
  int           wb_cnt = 0;
  int           fetch_cnt = 0;
  int           wait_cnt = 0;
  logic [31:0]  pend_addr = '0;
  logic         pend_w = 1'b0;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    if (mem_store.exists(a)) return mem_store[a];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = 32'h1000_0000 | (a + 32'(4 * w));
    return l;
  endfunction

  // Enable high for 10 cycles, ack in the 11th, read data in the cycle after ack.
  always @(negedge clk) begin
    logic was_ack;
    was_ack = mem_ack;
    if (was_ack) begin
      mem_ack = 1'b0;
      if (!pend_w) begin
        mem_rdata = line_of(pend_addr);
        check("enable_low_after_fetch_ack", {31'b0, mem_enable_o}, 32'd0);
      end
    end
    if (mem_enable_o) begin
      wait_cnt++;
      if (wait_cnt == 11) begin
        wait_cnt  = 0;
        mem_ack   = 1'b1;
        pend_addr = mem_addr_o;
        pend_w    = mem_write_o;
        if (mem_write_o) begin
          mem_store[mem_addr_o] = mem_data_o;
          wb_addr_log.push_back(mem_addr_o);
          wb_data_log.push_back(mem_data_o);
          wb_cnt++;
        end else begin
          fetch_cnt++;
        end
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output int stalls, output logic [31:0] rd, output logic timeout);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_write = w; cpu_addr = a; cpu_wdata = d;
    stalls = 0; rd = '0; timeout = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!cpu_stall_o) begin
        rd = cpu_data_o;
        timeout = 1'b0;
        break;
      end
      stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_write = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_data;
    int          exp_stall;
    int          exp_wb;
    int          exp_fetch;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int          st;
    logic [31:0] rd;
    logic        to;
    int          wb0, f0;
    logic [255:0] l;

    vecs[0]  = '{1'b0, 32'h0000_0040, 32'h0,          32'h1000_0040, 13, 0, 1};
    vecs[1]  = '{1'b0, 32'h0000_0044, 32'h0,          32'h1000_0044, 0,  0, 0};
    vecs[2]  = '{1'b1, 32'h0000_0048, 32'hDEAD_BEEF,  32'h0,         0,  0, 0};
    vecs[3]  = '{1'b0, 32'h0000_0048, 32'h0,          32'hDEAD_BEEF, 0,  0, 0};
    vecs[4]  = '{1'b0, 32'h0000_0440, 32'h0,          32'h1000_0440, 24, 1, 1};
    vecs[5]  = '{1'b1, 32'h0000_0080, 32'h1234_5678,  32'h0,         13, 0, 1};
    vecs[6]  = '{1'b0, 32'h0000_0080, 32'h0,          32'h1234_5678, 0,  0, 0};
    vecs[7]  = '{1'b0, 32'h0000_0084, 32'h0,          32'h1000_0084, 0,  0, 0};
    vecs[8]  = '{1'b0, 32'h0000_0040, 32'h0,          32'h1000_0040, 13, 0, 1};
    vecs[9]  = '{1'b0, 32'h0000_0048, 32'h0,          32'hDEAD_BEEF, 0,  0, 0};
    vecs[10] = '{1'b0, 32'h0000_1080, 32'h0,          32'h1000_1080, 24, 1, 1};
    vecs[11] = '{1'b0, 32'h0000_0080, 32'h0,          32'h1234_5678, 13, 0, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("reset_mem_enable", {31'b0, mem_enable_o}, 32'd0);
    check("reset_mem_write",  {31'b0, mem_write_o},  32'd0);
    check("reset_mem_addr",   mem_addr_o,            32'd0);
    check("reset_stall",      {31'b0, cpu_stall_o},  32'd0);
    check("reset_cpu_data",   cpu_data_o,            32'd0);

    for (int i = 0; i < 12; i++) begin
      wb0 = wb_cnt; f0 = fetch_cnt;
      do_access(vecs[i].w, vecs[i].a, vecs[i].d, st, rd, to);
      check($sformatf("v%0d_timeout", i), {31'b0, to}, 32'd0);
      check($sformatf("v%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
      if (!vecs[i].w) check($sformatf("v%0d_data", i), rd, vecs[i].exp_data);
      check($sformatf("v%0d_writebacks", i), 32'(wb_cnt - wb0), 32'(vecs[i].exp_wb));
      check($sformatf("v%0d_fetches", i), 32'(fetch_cnt - f0), 32'(vecs[i].exp_fetch));
    end

    check("wb_log_size", 32'(wb_addr_log.size()), 32'd2);
    if (wb_addr_log.size() >= 2) begin
      check("wb0_addr", wb_addr_log[0], 32'h0000_0040);
      l = wb_data_log[0];
      check("wb0_word2", l[95:64], 32'hDEAD_BEEF);
      check("wb0_word1", l[63:32], 32'h1000_0044);
      check("wb1_addr", wb_addr_log[1], 32'h0000_0080);
      l = wb_data_log[1];
      check("wb1_word0", l[31:0], 32'h1234_5678);
    end

    // Flush in the middle of a fetch of 0x440 (idx 2 currently holds tag 0, clean)
    f0 = fetch_cnt;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0440;
    @(negedge clk);
    check("miss_c0_stall", {31'b0, cpu_stall_o}, 32'd1);
    check("miss_c0_enable", {31'b0, mem_enable_o}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("alloc_enable", {31'b0, mem_enable_o}, 32'd1);
    check("alloc_write", {31'b0, mem_write_o}, 32'd0);
    check("alloc_addr", mem_addr_o, 32'h0000_0440);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_enable_drop", {31'b0, mem_enable_o}, 32'd0);
    check("flush_addr_zero", mem_addr_o, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    check("post_flush_enable", {31'b0, mem_enable_o}, 32'd0);
    check("post_flush_no_fetch", 32'(fetch_cnt - f0), 32'd0);

    f0 = fetch_cnt; wb0 = wb_cnt;
    do_access(1'b0, 32'h0000_0440, 32'h0, st, rd, to);
    check("reload_timeout", {31'b0, to}, 32'd0);
    check("reload_stall", 32'(st), 32'd13);
    check("reload_data", rd, 32'h1000_0440);
    check("reload_fetches", 32'(fetch_cnt - f0), 32'd1);
    check("reload_writebacks", 32'(wb_cnt - wb0), 32'd0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

endmodule
